fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one IMEM request at a time, buffers a response
// that arrives during a stall, and drives the registered IF/ID stage plus PC_Next.
module fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] PC_Next,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        load_new;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  always_comb begin
    state_d         = state_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    load_new        = 1'b0;
    load_instr      = imem_rdata;
    load_pc         = PC;
    imem_req        = 1'b0;
    imem_addr       = PC;
    pc_plus4        = PC + 32'd4;
    redirect_pc     = redirect_target_i & ~32'h0000_0003;

    unique case (state_q)
      ST_FETCH: begin
        if (!redirect_i) begin
          imem_req = 1'b1;
          if (imem_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_i) begin
            state_d = ST_FETCH;
          end else if (stall_i) begin
            state_d      = ST_HOLD;
            hold_instr_d = imem_rdata;
            hold_pc_d    = PC;
          end else begin
            load_new = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (redirect_i) begin
          state_d = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        load_instr = hold_instr_q;
        load_pc    = hold_pc_q;
        if (redirect_i) begin
          state_d = ST_FETCH;
        end else if (!stall_i) begin
          load_new = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Flush beats stall; stall keeps every IF/ID field, including pc fields.
    if (redirect_i) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall_i) begin
      if (load_new) begin
        ifid_valid_d    = 1'b1;
        ifid_instr_d    = load_instr;
        ifid_pc_d       = load_pc;
        ifid_pc_plus4_d = load_pc + 32'd4;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end

    if (redirect_i)    PC_Next = redirect_pc;
    else if (load_new) PC_Next = pc_plus4;
    else               PC_Next = PC;

    if (!rst) begin
      imem_req = 1'b0;
      PC_Next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_FETCH;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= 32'd4;
      hold_instr_q    <= '0;
      hold_pc_q       <= '0;
    end else begin
      state_q         <= state_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      hold_instr_q    <= hold_instr_d;
      hold_pc_q       <= hold_pc_d;
    end
  end

  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

endmodule
